// File: rtl/bath_mode_ctrl_pkg.sv
// rtl/bath_mode_ctrl_pkg.sv - state codes, display constants and BCD helpers for the bath panel sequencer
package bath_mode_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_WAKE    = 3'd1,
    ST_STANDBY = 3'd2,
    ST_RUN     = 3'd3,
    ST_HOLD    = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic [3:0] BLANK      = 4'hF;
  localparam int         NUM_DIGITS = 8;

  function automatic logic [6:0] sat99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    logic [6:0] s;
    s = sat99(v);
    return {4'(s / 7'd10), 4'(s % 7'd10)};
  endfunction

  // Timer layout is {min tens, min ones, sec tens, sec ones}; only called on a non-zero value.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = t;
    if (so != 4'd0) so = so - 4'd1;
    else begin
      so = 4'd9;
      if (st != 4'd0) st = st - 4'd1;
      else begin
        st = 4'd5;
        if (mo != 4'd0) mo = mo - 4'd1;
        else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

endpackage

// File: rtl/bath_mode_ctrl_disp_scan.sv
// rtl/bath_mode_ctrl_disp_scan.sv - multiplexed scanner for the shared 8-digit seven-segment display
module bath_mode_ctrl_disp_scan
  import bath_mode_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_digits,
  input  logic [7:0]  i_mask,
  output logic [3:0]  o_digit,
  output logic [7:0]  o_tube
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [DIV_W-1:0] r_div;
  logic [IDX_W-1:0] r_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (r_div == DIV_W'(SCAN_DIV - 1)) begin
      r_div <= '0;
      r_idx <= r_idx + 1'b1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Digit and tube both follow r_idx directly so they can never skew.
  assign o_digit = i_digits[{r_idx, 2'b00} +: 4];
  assign o_tube  = i_mask[r_idx] ? ~(8'h01 << r_idx) : 8'hFF;

endmodule

// File: rtl/bath_mode_ctrl.sv
// rtl/bath_mode_ctrl.sv - bath heater/shower mode sequencer with thermostat and display arbitration
module bath_mode_ctrl
  import bath_mode_ctrl_pkg::*;
#(
  parameter int WAKE_TICKS = 8,
  parameter int DONE_TICKS = 6,
  parameter int RUN_MIN    = 10,
  parameter int HYST       = 2,
  parameter int SCAN_DIV   = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_2hz,
  input  logic       openit,
  input  logic       start_key,
  input  logic       stop_key,
  input  logic [6:0] temp_set,
  input  logic [6:0] temp_cur,
  output logic [2:0] mode,
  output logic       heat_en,
  output logic       water_en,
  output logic       done_beep,
  output logic [3:0] disp_digit,
  output logic [7:0] tube
);

  localparam logic [15:0] TIMER_LOAD = {bin2bcd(7'(RUN_MIN)), 8'h00};

  state_t      r_state, w_key_ns, w_ns;
  logic [7:0]  r_tcnt, w_tcnt;
  logic        r_blink, w_blink, r_half, w_half;
  logic        r_heat, w_heat, r_water, r_beep;
  logic [15:0] r_timer, w_timer;
  logic [6:0]  w_ts, w_tc;
  logic [31:0] w_digits;
  logic [7:0]  w_mask;

  assign w_ts = sat99(temp_set);
  assign w_tc = sat99(temp_cur);

  always_comb begin
    w_key_ns = r_state;
    if (!openit) w_key_ns = ST_OFF;
    else begin
      case (r_state)
        ST_OFF:     w_key_ns = ST_WAKE;
        ST_STANDBY: if (start_key && !stop_key) w_key_ns = ST_RUN;
        ST_RUN:     if (stop_key) w_key_ns = ST_HOLD;
        ST_HOLD:    if (stop_key) w_key_ns = ST_STANDBY;
                    else if (start_key) w_key_ns = ST_RUN;
        default:    ;
      endcase
    end
  end

  // A key-driven change lands first; a coincident tick is then applied to the new state.
  always_comb begin
    w_ns    = w_key_ns;
    w_tcnt  = r_tcnt;
    w_blink = r_blink;
    w_half  = r_half;
    w_timer = r_timer;
    if (w_key_ns != r_state) begin
      w_tcnt  = 8'd0;
      w_blink = 1'b1;
    end
    if (tick_2hz) begin
      case (w_key_ns)
        ST_WAKE: begin
          w_tcnt  = w_tcnt + 8'd1;
          w_blink = ~w_blink;
          if (w_tcnt >= 8'(WAKE_TICKS)) w_ns = ST_STANDBY;
        end
        ST_DONE: begin
          w_tcnt  = w_tcnt + 8'd1;
          w_blink = ~w_blink;
          if (w_tcnt >= 8'(DONE_TICKS)) w_ns = ST_STANDBY;
        end
        ST_RUN: begin
          if (w_half) begin
            if (w_timer != 16'd0) w_timer = bcd_dec(w_timer);
            if (w_timer == 16'd0) w_ns = ST_DONE;
          end
          w_half = ~w_half;
        end
        ST_HOLD: w_blink = ~w_blink;
        default: ;
      endcase
    end
    if (w_ns != w_key_ns) begin
      w_tcnt  = 8'd0;
      w_blink = 1'b1;
    end
    if (w_ns != ST_RUN && w_ns != ST_HOLD) begin
      w_half  = 1'b0;
      w_timer = TIMER_LOAD;
    end
  end

  always_comb begin
    w_heat = 1'b0;
    if (r_state == ST_RUN && w_ns == ST_RUN) begin
      if ({1'b0, w_tc} + 8'(HYST) <= {1'b0, w_ts}) w_heat = 1'b1;
      else if (w_tc >= w_ts)                       w_heat = 1'b0;
      else                                         w_heat = r_heat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_OFF;
      r_tcnt  <= 8'd0;
      r_blink <= 1'b1;
      r_half  <= 1'b0;
      r_timer <= 16'd0;
      r_heat  <= 1'b0;
      r_water <= 1'b0;
      r_beep  <= 1'b0;
    end else begin
      r_state <= w_ns;
      r_tcnt  <= w_tcnt;
      r_blink <= w_blink;
      r_half  <= w_half;
      r_timer <= w_timer;
      r_heat  <= w_heat;
      r_water <= (w_ns == ST_RUN);
      r_beep  <= (w_ns == ST_DONE);
    end
  end

  always_comb begin
    w_digits = {NUM_DIGITS{BLANK}};
    w_mask   = 8'h00;
    case (r_state)
      ST_WAKE: begin
        w_digits = {NUM_DIGITS{4'd8}};
        w_mask   = r_blink ? 8'hFF : 8'h00;
      end
      ST_STANDBY: begin
        w_digits[7:0]   = bin2bcd(w_ts);
        w_digits[23:16] = bin2bcd(w_tc);
        w_mask          = 8'h33;
      end
      ST_RUN, ST_HOLD: begin
        w_digits[15:0]  = r_timer;
        w_digits[23:16] = bin2bcd(w_tc);
        w_mask          = (r_state == ST_RUN || r_blink) ? 8'h3F : 8'h30;
      end
      ST_DONE: begin
        w_digits[15:0] = 16'h0000;
        w_mask         = r_blink ? 8'h0F : 8'h00;
      end
      default: ;
    endcase
  end

  bath_mode_ctrl_disp_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_digits (w_digits),
    .i_mask   (w_mask),
    .o_digit  (disp_digit),
    .o_tube   (tube)
  );

  assign mode      = r_state;
  assign heat_en   = r_heat;
  assign water_en  = r_water;
  assign done_beep = r_beep;

endmodule

// File: doc/bath_mode_ctrl.md
Name: bath_mode_ctrl

Overview:
Top-level mode sequencer for the bathroom heater/shower panel. Sequences power-on (wake blink), standby, timed run with thermostat control, pause and completion. Arbitrates the shared 8-digit seven-segment display between the wake, standby, run and done views. Drives the existing BCD-to-segment decoder through disp_digit and the tube enables directly.

Parameters:
WAKE_TICKS, 8, tick_2hz pulses spent in WAKE (blink period = 2 ticks)
DONE_TICKS, 6, tick_2hz pulses spent in DONE
RUN_MIN, 10, run duration minutes (BCD-loaded, 0..99)
HYST, 2, thermostat hysteresis in degC
SCAN_DIV, 1024, clk cycles per display digit slot

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
tick_2hz  in  1  single-clk enable pulse at 2 Hz, synchronous to clk
openit  in  1  power switch level, 1 = on
start_key  in  1  debounced single-cycle pulse
stop_key  in  1  debounced single-cycle pulse
temp_set  in  7  target temperature degC, 0..99
temp_cur  in  7  measured temperature degC, 0..99
mode  out  3  current FSM state code
heat_en  out  1  heater on
water_en  out  1  water valve open
done_beep  out  1  high throughout DONE
disp_digit  out  4  BCD value for active tube; 4'hF = blank
tube  out  8  tube enables, active-low, one-hot-low or all-high

Behaviour:
- Reset (rst_n=0 at clk edge): state OFF, all counters 0, heat_en=water_en=done_beep=0, tube=8'hFF, disp_digit=4'hF.
- openit=0 forces OFF on the next edge from any state; overrides keys. Timer is reloaded on re-entry.
- Codes: OFF=0, WAKE=1, STANDBY=2, RUN=3, HOLD=4, DONE=5.
- OFF: outputs idle. openit=1 -> WAKE, tick counter cleared.
- WAKE: all 8 tubes show 8. blink phase toggles on each tick_2hz, starting visible; phase 0 -> tube=8'hFF. After WAKE_TICKS ticks -> STANDBY.
- STANDBY:
  - digits 1:0 show temp_set, digits 5:4 show temp_cur, others blank.
  - Timer is held at RUN_MIN:00 (BCD min tens/ones, sec tens/ones).
  - start_key -> RUN.
- RUN:
  - water_en=1.
  - heat_en set when temp_cur + HYST <= temp_set; cleared when temp_cur >= temp_set; otherwise held. heat_en=0 on RUN entry, evaluated from the next cycle.
  - Timer decrements 1 s every 2nd tick; sec wraps 00 -> 59 with a minute borrow.
  - Digits 3:0 show mm:ss remaining; digits 5:4 show temp_cur.
  - At 00:00 after a decrement -> DONE.
  - stop_key -> HOLD.
- HOLD:
  - heat_en=water_en=0; timer frozen; display as RUN with digits 3:0 blinking.
  - start_key -> RUN (resume, half-second phase kept).
  - stop_key -> STANDBY (timer reloaded).
- DONE:
  - heat_en=water_en=0, done_beep=1; digits 3:0 show 00:00 blinking.
  - After DONE_TICKS ticks -> STANDBY.
- start_key and stop_key in the same cycle: stop wins.
- A tick coincident with a state change counts in the new state only.
- RUN_MIN=0: start_key goes RUN -> DONE on the first second boundary.
- Temperature inputs >99 saturate to 99 for display and compare.
- Scanner: free-running counter. Digit index 0..7 advances every SCAN_DIV clks and wraps 7 -> 0.
  - tube = ~(8'b1 << idx) if the digit is visible, else 8'hFF.
  - disp_digit updates in the same cycle as tube (no skew).
  - The scanner keeps running in OFF, but tube stays 8'hFF.

Decomposition:
- Shared include bath_defs.vh: state codes, BLANK=4'hF, seven-seg digit count.
- Sub-module bath_disp_scan: scan counter, digit mux from a 32-bit digit vector plus an 8-bit visible mask, tube/disp_digit generation.
- Binary-to-two-digit BCD conversion (0..99) is a combinational function in bath_defs.vh.

Test Plan:
- Sim params: tick every 4 clk, SCAN_DIV=2, RUN_MIN=1, WAKE_TICKS=8.
- Reset low 3 clk with openit=1, then release -> mode=0 during reset, mode=1 first edge after, mode=2 after 8 ticks; during WAKE, tube alternates all-off/scan with disp_digit=8.
- STANDBY, temp_set=45, temp_cur=30 -> idx0 shows 5, idx1 4, idx4 0, idx5 3, tube idx 2,3,6,7 never low.
- start_key, temp_cur ramps 30 -> 45 -> 44 -> 43 -> heat_en 1 until 45, stays 0 at 44, returns 1 at 43; water_en=1 throughout.
- RUN from 01:00: 120 ticks -> display passes 00:59 after 2 ticks; DONE with done_beep=1, after 6 ticks mode=2.
- In RUN at 00:40: stop_key -> HOLD and timer frozen 20 ticks; start_key -> resumes 00:40. stop_key twice -> STANDBY and timer back to 01:00.
- start_key and stop_key same cycle in RUN -> HOLD. openit=0 mid-RUN -> next edge mode=0, heat_en=water_en=0, tube=8'hFF.
